// File: rtl/slot_index_encoder.sv
// rtl/slot_index_encoder.sv - first-free-slot zero counter and one-hot index encoder
// Combinational results for same-cycle table updates plus sampled registered copies.
module slot_index_encoder #(
    parameter  int WIDTH = 8,
    parameter  int MODE  = 0,
    localparam int IDX_W = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] free_vec_i,
    input  logic [WIDTH-1:0] match_vec_i,
    input  logic             sample_i,
    output logic [IDX_W-1:0] free_idx_o,
    output logic             free_empty_o,
    output logic [IDX_W-1:0] match_idx_o,
    output logic             match_any_o,
    output logic             match_multi_o,
    output logic [IDX_W-1:0] free_idx_q_o,
    output logic             free_empty_q_o,
    output logic [IDX_W-1:0] match_idx_q_o,
    output logic             match_any_q_o,
    output logic             match_multi_q_o
);

    logic [IDX_W-1:0] free_idx;
    logic             free_empty;
    logic [IDX_W-1:0] match_idx;
    logic             match_any;
    logic             match_multi;

    logic [IDX_W-1:0] free_idx_d,    free_idx_q;
    logic             free_empty_d,  free_empty_q;
    logic [IDX_W-1:0] match_idx_d,   match_idx_q;
    logic             match_any_d,   match_any_q;
    logic             match_multi_d, match_multi_q;

    // The loop direction makes the last hit win: lowest set bit for MODE 0,
    // highest set bit (reported as zeros above it) for MODE 1.
    always_comb begin
        free_idx   = '0;
        free_empty = 1'b1;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (free_vec_i[i]) begin
                    free_idx   = IDX_W'(i);
                    free_empty = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (free_vec_i[i]) begin
                    free_idx   = IDX_W'(WIDTH - 1 - i);
                    free_empty = 1'b0;
                end
            end
        end
    end

    // OR-of-indices encoder; multi-hot flags a second set bit after the first.
    always_comb begin
        match_idx   = '0;
        match_any   = 1'b0;
        match_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (match_vec_i[i]) begin
                match_multi = match_multi | match_any;
                match_any   = 1'b1;
                match_idx   = match_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        free_idx_d    = free_idx_q;
        free_empty_d  = free_empty_q;
        match_idx_d   = match_idx_q;
        match_any_d   = match_any_q;
        match_multi_d = match_multi_q;
        if (sample_i) begin
            free_idx_d    = free_idx;
            free_empty_d  = free_empty;
            match_idx_d   = match_idx;
            match_any_d   = match_any;
            match_multi_d = match_multi;
        end
    end

    // Reset leaves free_empty set so an idle status register reads "no free slot".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_idx_q    <= '0;
            free_empty_q  <= 1'b1;
            match_idx_q   <= '0;
            match_any_q   <= 1'b0;
            match_multi_q <= 1'b0;
        end else begin
            free_idx_q    <= free_idx_d;
            free_empty_q  <= free_empty_d;
            match_idx_q   <= match_idx_d;
            match_any_q   <= match_any_d;
            match_multi_q <= match_multi_d;
        end
    end

    assign free_idx_o      = free_idx;
    assign free_empty_o    = free_empty;
    assign match_idx_o     = match_idx;
    assign match_any_o     = match_any;
    assign match_multi_o   = match_multi;
    assign free_idx_q_o    = free_idx_q;
    assign free_empty_q_o  = free_empty_q;
    assign match_idx_q_o   = match_idx_q;
    assign match_any_q_o   = match_any_q;
    assign match_multi_q_o = match_multi_q;

endmodule

// File: tb/tb_slot_index_encoder.sv
// tb/tb_slot_index_encoder.sv - directed and exhaustive checks against a behavioural model
module tb_slot_index_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample;
    logic [7:0] f8, m8;
    logic [4:0] f5, m5;
    logic [0:0] f1, m1;
    bit         cmp_en = 1'b0;
    int         checks = 0;
    int         errors = 0;

    assign f5 = f8[4:0];
    assign m5 = m8[4:0];
    assign f1 = f8[0:0];
    assign m1 = m8[0:0];

    always #5 clk = ~clk;

    logic [2:0] o0_fidx, o0_midx, o0_fidx_q, o0_midx_q;
    logic       o0_fe, o0_many, o0_mmulti, o0_fe_q, o0_many_q, o0_mmulti_q;
    logic [2:0] o1_fidx, o1_midx, o1_fidx_q, o1_midx_q;
    logic       o1_fe, o1_many, o1_mmulti, o1_fe_q, o1_many_q, o1_mmulti_q;
    logic [2:0] o2_fidx, o2_midx, o2_fidx_q, o2_midx_q;
    logic       o2_fe, o2_many, o2_mmulti, o2_fe_q, o2_many_q, o2_mmulti_q;
    logic [2:0] o3_fidx, o3_midx, o3_fidx_q, o3_midx_q;
    logic       o3_fe, o3_many, o3_mmulti, o3_fe_q, o3_many_q, o3_mmulti_q;
    logic [0:0] o4_fidx, o4_midx, o4_fidx_q, o4_midx_q;
    logic       o4_fe, o4_many, o4_mmulti, o4_fe_q, o4_many_q, o4_mmulti_q;
    logic [0:0] o5_fidx, o5_midx, o5_fidx_q, o5_midx_q;
    logic       o5_fe, o5_many, o5_mmulti, o5_fe_q, o5_many_q, o5_mmulti_q;

    slot_index_encoder #(.WIDTH(8), .MODE(0)) u_w8m0 (
        .clk_i(clk), .rst_i(rst), .free_vec_i(f8), .match_vec_i(m8), .sample_i(sample),
        .free_idx_o(o0_fidx), .free_empty_o(o0_fe), .match_idx_o(o0_midx),
        .match_any_o(o0_many), .match_multi_o(o0_mmulti),
        .free_idx_q_o(o0_fidx_q), .free_empty_q_o(o0_fe_q), .match_idx_q_o(o0_midx_q),
        .match_any_q_o(o0_many_q), .match_multi_q_o(o0_mmulti_q));

    slot_index_encoder #(.WIDTH(8), .MODE(1)) u_w8m1 (
        .clk_i(clk), .rst_i(rst), .free_vec_i(f8), .match_vec_i(m8), .sample_i(sample),
        .free_idx_o(o1_fidx), .free_empty_o(o1_fe), .match_idx_o(o1_midx),
        .match_any_o(o1_many), .match_multi_o(o1_mmulti),
        .free_idx_q_o(o1_fidx_q), .free_empty_q_o(o1_fe_q), .match_idx_q_o(o1_midx_q),
        .match_any_q_o(o1_many_q), .match_multi_q_o(o1_mmulti_q));

    slot_index_encoder #(.WIDTH(5), .MODE(0)) u_w5m0 (
        .clk_i(clk), .rst_i(rst), .free_vec_i(f5), .match_vec_i(m5), .sample_i(sample),
        .free_idx_o(o2_fidx), .free_empty_o(o2_fe), .match_idx_o(o2_midx),
        .match_any_o(o2_many), .match_multi_o(o2_mmulti),
        .free_idx_q_o(o2_fidx_q), .free_empty_q_o(o2_fe_q), .match_idx_q_o(o2_midx_q),
        .match_any_q_o(o2_many_q), .match_multi_q_o(o2_mmulti_q));

    slot_index_encoder #(.WIDTH(5), .MODE(1)) u_w5m1 (
        .clk_i(clk), .rst_i(rst), .free_vec_i(f5), .match_vec_i(m5), .sample_i(sample),
        .free_idx_o(o3_fidx), .free_empty_o(o3_fe), .match_idx_o(o3_midx),
        .match_any_o(o3_many), .match_multi_o(o3_mmulti),
        .free_idx_q_o(o3_fidx_q), .free_empty_q_o(o3_fe_q), .match_idx_q_o(o3_midx_q),
        .match_any_q_o(o3_many_q), .match_multi_q_o(o3_mmulti_q));

    slot_index_encoder #(.WIDTH(1), .MODE(0)) u_w1m0 (
        .clk_i(clk), .rst_i(rst), .free_vec_i(f1), .match_vec_i(m1), .sample_i(sample),
        .free_idx_o(o4_fidx), .free_empty_o(o4_fe), .match_idx_o(o4_midx),
        .match_any_o(o4_many), .match_multi_o(o4_mmulti),
        .free_idx_q_o(o4_fidx_q), .free_empty_q_o(o4_fe_q), .match_idx_q_o(o4_midx_q),
        .match_any_q_o(o4_many_q), .match_multi_q_o(o4_mmulti_q));

    slot_index_encoder #(.WIDTH(1), .MODE(1)) u_w1m1 (
        .clk_i(clk), .rst_i(rst), .free_vec_i(f1), .match_vec_i(m1), .sample_i(sample),
        .free_idx_o(o5_fidx), .free_empty_o(o5_fe), .match_idx_o(o5_midx),
        .match_any_o(o5_many), .match_multi_o(o5_mmulti),
        .free_idx_q_o(o5_fidx_q), .free_empty_q_o(o5_fe_q), .match_idx_q_o(o5_midx_q),
        .match_any_q_o(o5_many_q), .match_multi_q_o(o5_mmulti_q));

    // ---------------- behavioural model ----------------
    int W  [6] = '{8, 8, 5, 5, 1, 1};
    int MD [6] = '{0, 1, 0, 1, 0, 1};
    int eq_fidx [6];
    int eq_fe   [6];
    int eq_midx [6];
    int eq_many [6];
    int eq_multi[6];

    function automatic int fin(int id);
        return int'(f8) & ((1 << W[id]) - 1);
    endfunction

    function automatic int min_(int id);
        return int'(m8) & ((1 << W[id]) - 1);
    endfunction

    // v & -v isolates the lowest set bit; $clog2(v+1)-1 is the highest set position.
    function automatic int m_free_idx(int v, int w, int mode);
        if (v == 0) return 0;
        if (mode == 0) return $clog2(v & -v);
        return w - 1 - ($clog2(v + 1) - 1);
    endfunction

    function automatic int m_match_idx(int v, int w);
        int r = 0;
        for (int i = 0; i < w; i++)
            if (((v >> i) & 1) != 0) r = r | i;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int id = 0; id < 6; id++) begin
            if (rst) begin
                eq_fidx[id]  <= 0;
                eq_fe[id]    <= 1;
                eq_midx[id]  <= 0;
                eq_many[id]  <= 0;
                eq_multi[id] <= 0;
            end else if (sample) begin
                eq_fidx[id]  <= m_free_idx(fin(id), W[id], MD[id]);
                eq_fe[id]    <= (fin(id) == 0) ? 1 : 0;
                eq_midx[id]  <= m_match_idx(min_(id), W[id]);
                eq_many[id]  <= (min_(id) != 0) ? 1 : 0;
                eq_multi[id] <= ($countones(min_(id)) > 1) ? 1 : 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (f8=%h m8=%h t=%0t)", name, act, exp, f8, m8, $time);
        end
    endtask

    task automatic cmp_inst(input int id,
                            input logic [31:0] fidx, input logic [31:0] fe,
                            input logic [31:0] midx, input logic [31:0] many,
                            input logic [31:0] mmulti,
                            input logic [31:0] fidx_q, input logic [31:0] fe_q,
                            input logic [31:0] midx_q, input logic [31:0] many_q,
                            input logic [31:0] mmulti_q);
        int fv = fin(id);
        int mv = min_(id);
        chk($sformatf("u%0d free_idx", id),    fidx,   32'(m_free_idx(fv, W[id], MD[id])));
        chk($sformatf("u%0d free_empty", id),  fe,     32'(fv == 0));
        chk($sformatf("u%0d match_idx", id),   midx,   32'(m_match_idx(mv, W[id])));
        chk($sformatf("u%0d match_any", id),   many,   32'(mv != 0));
        chk($sformatf("u%0d match_multi", id), mmulti, 32'($countones(mv) > 1));
        chk($sformatf("u%0d idx_range", id),
            32'((fidx <= 32'(W[id] - 1)) && (midx <= 32'(W[id] - 1) || mv == 0 || $countones(mv) > 1)), 32'd1);
        chk($sformatf("u%0d free_idx_q", id),    fidx_q,   32'(eq_fidx[id]));
        chk($sformatf("u%0d free_empty_q", id),  fe_q,     32'(eq_fe[id]));
        chk($sformatf("u%0d match_idx_q", id),   midx_q,   32'(eq_midx[id]));
        chk($sformatf("u%0d match_any_q", id),   many_q,   32'(eq_many[id]));
        chk($sformatf("u%0d match_multi_q", id), mmulti_q, 32'(eq_multi[id]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, 32'(o0_fidx), 32'(o0_fe), 32'(o0_midx), 32'(o0_many), 32'(o0_mmulti),
                     32'(o0_fidx_q), 32'(o0_fe_q), 32'(o0_midx_q), 32'(o0_many_q), 32'(o0_mmulti_q));
            cmp_inst(1, 32'(o1_fidx), 32'(o1_fe), 32'(o1_midx), 32'(o1_many), 32'(o1_mmulti),
                     32'(o1_fidx_q), 32'(o1_fe_q), 32'(o1_midx_q), 32'(o1_many_q), 32'(o1_mmulti_q));
            cmp_inst(2, 32'(o2_fidx), 32'(o2_fe), 32'(o2_midx), 32'(o2_many), 32'(o2_mmulti),
                     32'(o2_fidx_q), 32'(o2_fe_q), 32'(o2_midx_q), 32'(o2_many_q), 32'(o2_mmulti_q));
            cmp_inst(3, 32'(o3_fidx), 32'(o3_fe), 32'(o3_midx), 32'(o3_many), 32'(o3_mmulti),
                     32'(o3_fidx_q), 32'(o3_fe_q), 32'(o3_midx_q), 32'(o3_many_q), 32'(o3_mmulti_q));
            cmp_inst(4, 32'(o4_fidx), 32'(o4_fe), 32'(o4_midx), 32'(o4_many), 32'(o4_mmulti),
                     32'(o4_fidx_q), 32'(o4_fe_q), 32'(o4_midx_q), 32'(o4_many_q), 32'(o4_mmulti_q));
            cmp_inst(5, 32'(o5_fidx), 32'(o5_fe), 32'(o5_midx), 32'(o5_many), 32'(o5_mmulti),
                     32'(o5_fidx_q), 32'(o5_fe_q), 32'(o5_midx_q), 32'(o5_many_q), 32'(o5_mmulti_q));
        end
    end

    // Inputs change 1 time unit after the rising edge; results are read on the falling edge.
    task automatic apply(input logic [7:0] f, input logic [7:0] m, input logic s, input logic r);
        @(posedge clk);
        #1;
        f8     = f;
        m8     = m;
        sample = s;
        rst    = r;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] onehot;
        rst    = 1'b1;
        sample = 1'b0;
        f8     = '0;
        m8     = '0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        apply(8'h00, 8'h00, 1'b0, 1'b1);
        chk("reset free_empty_q", 32'(o0_fe_q), 32'd1);
        chk("reset free_idx_q", 32'(o0_fidx_q), 32'd0);
        chk("reset match_any_q", 32'(o0_many_q), 32'd0);

        apply(8'b0010_1000, 8'h00, 1'b1, 1'b0);
        chk("m0 ctz 0x28", 32'(o0_fidx), 32'd3);
        chk("m0 empty 0x28", 32'(o0_fe), 32'd0);
        chk("m1 clz 0x28", 32'(o1_fidx), 32'd2);
        chk("w5m1 clz 0x08", 32'(o3_fidx), 32'd1);

        apply(8'h00, 8'b0000_0110, 1'b0, 1'b0);
        chk("m0 free_idx_q 0x28", 32'(o0_fidx_q), 32'd3);
        chk("m0 empty all-zero", 32'(o0_fe), 32'd1);
        chk("m0 idx all-zero", 32'(o0_fidx), 32'd0);
        chk("m1 empty all-zero", 32'(o1_fe), 32'd1);
        chk("m1 idx all-zero", 32'(o1_fidx), 32'd0);
        chk("multi-hot idx 0x06", 32'(o0_midx), 32'd3);
        chk("multi-hot flag 0x06", 32'(o0_mmulti), 32'd1);

        for (int k = 0; k < 8; k++) begin
            onehot = 8'd1 << k;
            apply(8'h00, onehot, 1'b0, 1'b0);
            chk($sformatf("onehot idx k=%0d", k), 32'(o0_midx), 32'(k));
            chk($sformatf("onehot any k=%0d", k), 32'(o0_many), 32'd1);
            chk($sformatf("onehot multi k=%0d", k), 32'(o0_mmulti), 32'd0);
        end

        apply(8'h00, 8'h00, 1'b0, 1'b0);
        chk("match none any", 32'(o0_many), 32'd0);
        chk("match none idx", 32'(o0_midx), 32'd0);

        apply(8'h80, 8'h40, 1'b1, 1'b0);
        apply(8'h13, 8'h01, 1'b0, 1'b0);
        chk("hold load free_idx_q", 32'(o0_fidx_q), 32'd7);
        chk("hold load match_idx_q", 32'(o0_midx_q), 32'd6);
        apply(8'h02, 8'h81, 1'b0, 1'b0);
        chk("hold 1 free_idx_q", 32'(o0_fidx_q), 32'd7);
        apply(8'hff, 8'h00, 1'b0, 1'b0);
        chk("hold 2 free_idx_q", 32'(o0_fidx_q), 32'd7);
        apply(8'h04, 8'h20, 1'b1, 1'b1);
        chk("hold 3 free_idx_q", 32'(o0_fidx_q), 32'd7);
        chk("comb during reset", 32'(o0_fidx), 32'd2);
        apply(8'h80, 8'h40, 1'b0, 1'b0);
        chk("rst>sample free_idx_q", 32'(o0_fidx_q), 32'd0);
        chk("rst>sample free_empty_q", 32'(o0_fe_q), 32'd1);
        chk("rst>sample match_idx_q", 32'(o0_midx_q), 32'd0);
        chk("rst>sample match_any_q", 32'(o0_many_q), 32'd0);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            apply(v, v ^ 8'h5A, v[0] ^ v[3], 1'b0);
        end

        apply(8'h00, 8'h00, 1'b0, 1'b0);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slot_index_encoder.md
# slot_index_encoder

Index-encoding helper for the AXI monitor's transaction tracking tables. It has two encoder paths. The first is a leading/trailing-zero counter that returns the first free slot of a free-bit vector. The second is a one-hot-to-binary converter that returns the index of the table entry matching an ID. Both results are available combinationally for same-cycle table updates, and as registered copies for pipelined consumers such as status registers.

## Interface
Parameters:
- WIDTH, default 8: number of table slots; must be ≥ 1.
- MODE, default 0: 0 = count trailing zeros (search from bit 0); 1 = count leading zeros (search from bit WIDTH-1).
- IDX_W, derived (not overridable): 1 if WIDTH = 1, else ceil(log2(WIDTH)).

Ports:
- clk_i  in  1  clock; all registers on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- free_vec_i  in  WIDTH  bit i = 1 means slot i is free.
- match_vec_i  in  WIDTH  one-hot match vector; bit i = 1 means entry i matches.
- sample_i  in  1  when 1, the registered outputs capture this cycle's results.
- free_idx_o  out  IDX_W  combinational zero count of free_vec_i.
- free_empty_o  out  1  combinational; 1 when free_vec_i == 0.
- match_idx_o  out  IDX_W  combinational binary index of match_vec_i.
- match_any_o  out  1  combinational; 1 when match_vec_i != 0.
- match_multi_o  out  1  combinational; 1 when more than one bit of match_vec_i is set.
- free_idx_q_o, free_empty_q_o, match_idx_q_o, match_any_q_o, match_multi_q_o  out  same widths  registered copies.

## Operation
Zero counter (MODE 0):
- free_idx_o = lowest i with free_vec_i[i] = 1.

Zero counter (MODE 1):
- free_idx_o = number of zeros above the highest set bit, i.e. WIDTH-1 minus the highest set index.

Zero counter, both modes:
- If free_vec_i == 0: free_empty_o = 1 and free_idx_o = 0.
- WIDTH = 1: free_idx_o is always 0 and free_empty_o = !free_vec_i[0].

One-hot decoder:
- match_idx_o = bitwise OR of the binary indices i of all set bits.
- For a valid one-hot input this is exactly the set index.
- All-zero input gives 0 with match_any_o = 0.
- Multi-hot input gives the OR of the indices with match_multi_o = 1. Callers must treat match_idx_o as invalid in that case.
- WIDTH = 1: match_idx_o is always 0.

Both paths are purely combinational. There is no internal state apart from the output registers.

Arithmetic:
- Indices are unsigned, IDX_W bits wide.
- For non-power-of-two WIDTH, indices never exceed WIDTH-1.

## Timing
- Combinational outputs settle in the same cycle as their inputs; there are no registers on that path.
- Registered outputs:
  - On a rising edge with rst_i = 1, all registered outputs clear to 0, except free_empty_q_o, which resets to 1.
  - Otherwise, with sample_i = 1, they capture the current combinational values.
  - Otherwise they hold.
- Registered latency is exactly 1 cycle from sample_i.
- rst_i has priority over sample_i on the same edge.
- Reset asserted mid-operation clears the registers on the next edge. The combinational outputs keep following the inputs during reset.
- There is no handshake and no backpressure. free_vec_i and match_vec_i may change every cycle.

## Test plan
All scenarios use WIDTH = 8 unless stated.
- MODE 0, free_vec_i = 8'b0010_1000 -> free_idx_o = 3, free_empty_o = 0. With sample_i = 1, free_idx_q_o = 3 one cycle later.
- MODE 1, free_vec_i = 8'b0010_1000 -> free_idx_o = 2. free_vec_i = 0 -> free_empty_o = 1, free_idx_o = 0 in both modes.
- match_vec_i sweeping each one-hot value 8'b1 << k, k = 0..7 -> match_idx_o = k, match_any_o = 1, match_multi_o = 0.
- match_vec_i = 8'b0000_0110 -> match_idx_o = 3 (1 | 2), match_multi_o = 1. match_vec_i = 0 -> match_any_o = 0, match_idx_o = 0.
- Load the registers (free_vec_i = 8'b1000_0000, sample_i = 1), then hold sample_i = 0 for 3 cycles while inputs change -> registered outputs stay at idx 7. Then assert rst_i and sample_i together -> next edge gives all registered outputs 0 and free_empty_q_o = 1.
- WIDTH = 5 and WIDTH = 1 builds, exhaustive free_vec_i and match_vec_i -> results match a behavioural model; no index exceeds WIDTH-1.
